// File: rtl/mc_state_sequencer.sv
// ---------------------------------------------------------------------------
// mc_state_sequencer
//
// Next-state sequencer for the multi-cycle RISC-V core. It holds the 4-bit
// state register that drives the combinational micro-controller. It steps
// through fetch, decode, execute, memory and write-back according to the
// opcode class in IR. It stops in HALT on ECALL or on an unknown opcode.
// It also keeps free-running cycle and retired-instruction counters.
//
// Ports
//   clk            core clock; all state updates on the rising edge
//   reset          synchronous, active-high; wins over every transition
//   opcode[6:0]    IR[6:0]; sampled only in ID, EX_2 and MEM_4
//   current_state  state register, consumed by the micro-controller
//   halted         high while the state register holds HALT
//   illegal_op     sticky; HALT was entered on an unknown opcode
//   cycle_count    non-HALT cycles since reset (wraps)
//   retired_count  completed instructions since reset (wraps)
// ---------------------------------------------------------------------------
module mc_state_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    output logic [3:0]       current_state,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [3:0] {
        S_IF_1  = 4'd0,
        S_IF_2  = 4'd1,
        S_IF_3  = 4'd2,
        S_IF_4  = 4'd3,
        S_ID    = 4'd4,
        S_EX_1  = 4'd5,
        S_EX_2  = 4'd6,
        S_MEM_1 = 4'd7,
        S_MEM_2 = 4'd8,
        S_MEM_3 = 4'd9,
        S_MEM_4 = 4'd10,
        S_WB    = 4'd11,
        S_HALT  = 4'd12
    } state_t;

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           next_state_s;
    logic             retire_s;
    logic             set_illegal_s;
    logic             cycle_en_s;
    logic             illegal_op_r;
    logic [CNT_W-1:0] cycle_count_r;
    logic [CNT_W-1:0] retired_count_r;

    // Next-state decode plus the retire / illegal-opcode events of this cycle
    always_comb begin
        next_state_s  = state_r;
        retire_s      = 1'b0;
        set_illegal_s = 1'b0;
        cycle_en_s    = 1'b1;
        case (state_r)
            S_IF_1:  next_state_s = S_IF_2;
            S_IF_2:  next_state_s = S_IF_3;
            S_IF_3:  next_state_s = S_IF_4;
            S_IF_4:  next_state_s = S_ID;
            S_ID: begin
                case (opcode)
                    OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
                    OP_BRANCH, OP_JAL, OP_JALR: begin
                        next_state_s = S_EX_1;
                    end
                    OP_ECALL: begin
                        // ECALL completes the moment it is decoded
                        next_state_s = S_HALT;
                        retire_s     = 1'b1;
                    end
                    default: begin
                        next_state_s  = S_HALT;
                        set_illegal_s = 1'b1;
                    end
                endcase
            end
            S_EX_1:  next_state_s = S_EX_2;
            S_EX_2: begin
                case (opcode)
                    OP_LOAD, OP_STORE: begin
                        next_state_s = S_MEM_1;
                    end
                    OP_BRANCH: begin
                        // PC already updated in EX_1/EX_2; nothing to write back
                        next_state_s = S_IF_1;
                        retire_s     = 1'b1;
                    end
                    default: begin
                        // ARITHMETIC, ARITHMETIC_IMM, JAL, JALR
                        next_state_s = S_WB;
                    end
                endcase
            end
            S_MEM_1: next_state_s = S_MEM_2;
            S_MEM_2: next_state_s = S_MEM_3;
            S_MEM_3: next_state_s = S_MEM_4;
            S_MEM_4: begin
                if (opcode == OP_STORE) begin
                    next_state_s = S_IF_1;
                    retire_s     = 1'b1;
                end else begin
                    next_state_s = S_WB;
                end
            end
            S_WB: begin
                next_state_s = S_IF_1;
                retire_s     = 1'b1;
            end
            S_HALT: begin
                next_state_s = S_HALT;
                cycle_en_s   = 1'b0;
            end
            default: begin
                // Unused codes recover to fetch silently: no count, no flag
                next_state_s = S_IF_1;
                cycle_en_s   = 1'b0;
            end
        endcase
    end

    // State register, sticky illegal flag and both event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= S_IF_1;
            illegal_op_r    <= 1'b0;
            cycle_count_r   <= {CNT_W{1'b0}};
            retired_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (set_illegal_s) begin
                illegal_op_r <= 1'b1;
            end else begin
                illegal_op_r <= illegal_op_r;
            end
            if (cycle_en_s) begin
                cycle_count_r <= cycle_count_r + CNT_ONE;
            end else begin
                cycle_count_r <= cycle_count_r;
            end
            if (retire_s) begin
                retired_count_r <= retired_count_r + CNT_ONE;
            end else begin
                retired_count_r <= retired_count_r;
            end
        end
    end

    assign current_state = state_r;
    assign halted        = (state_r == S_HALT);
    assign illegal_op    = illegal_op_r;
    assign cycle_count   = cycle_count_r;
    assign retired_count = retired_count_r;

endmodule

// File: tb/tb_mc_state_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mc_state_sequencer
//
// Drives whole instructions into mc_state_sequencer. The reference model
// describes each instruction class as the list of states it visits after
// IF_1, together with whether its last step retires or halts. Opcode is
// randomised in every state where it must be ignored. Resets are injected
// mid-instruction, and HALT is held with random opcodes.
// ---------------------------------------------------------------------------
module tb_mc_state_sequencer;

    localparam int CNT_W = 32;

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    logic             clk;
    logic             reset;
    logic [6:0]       opcode;
    logic [3:0]       current_state;
    logic             halted;
    logic             illegal_op;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retired_count;

    mc_state_sequencer #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .current_state (current_state),
        .halted        (halted),
        .illegal_op    (illegal_op),
        .cycle_count   (cycle_count),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // reference model state
    int          exp_state = 0;
    logic        exp_ill   = 1'b0;
    logic [31:0] exp_cycle = 32'd0;
    logic [31:0] exp_ret   = 32'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".state"},   {28'd0, current_state}, exp_state);
        check_val({tag, ".halted"},  {31'd0, halted},  {31'd0, (exp_state == 12)});
        check_val({tag, ".illegal"}, {31'd0, illegal_op}, {31'd0, exp_ill});
        check_val({tag, ".cycles"},  cycle_count,  exp_cycle);
        check_val({tag, ".retired"}, retired_count, exp_ret);
    endtask

    // One clock: inputs applied on the falling edge, outputs settle after rise
    task automatic one_edge(input logic [6:0] op, input logic rst);
        @(negedge clk);
        opcode = op;
        reset  = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        one_edge(7'($urandom), 1'b1);
        exp_state = 0;
        exp_ill   = 1'b0;
        exp_cycle = 32'd0;
        exp_ret   = 32'd0;
        check_all(tag);
    endtask

    // States visited after IF_1, ending in IF_1 again or HALT.
    // kind: 0 retires at end, 1 illegal halt (no retire)
    task automatic build_path(input logic [6:0] op, output int path[$], output int kind);
        path = '{1, 2, 3, 4};
        kind = 0;
        case (op)
            OP_ARITH, OP_ARITH_IMM, OP_JAL, OP_JALR: path = {path, 5, 6, 11, 0};
            OP_LOAD:   path = {path, 5, 6, 7, 8, 9, 10, 11, 0};
            OP_STORE:  path = {path, 5, 6, 7, 8, 9, 10, 0};
            OP_BRANCH: path = {path, 5, 6, 0};
            OP_ECALL:  path = {path, 12};
            default: begin
                path = {path, 12};
                kind = 1;
            end
        endcase
    endtask

    // Runs one instruction starting in IF_1; rst_at >= 0 resets at that step
    task automatic do_instr(input logic [6:0] op, input int rst_at);
        int path[$];
        int kind;
        int pres;
        logic [6:0] drv;
        build_path(op, path, kind);
        for (int k = 0; k < path.size(); k++) begin
            pres = (k == 0) ? 0 : path[k-1];
            // opcode only matters in ID, EX_2, MEM_4; elsewhere drive junk
            drv = (pres == 4 || pres == 6 || pres == 10) ? op : 7'($urandom);
            if (k == rst_at) begin
                do_reset("mid_rst");
                return;
            end
            one_edge(drv, 1'b0);
            exp_cycle = exp_cycle + 32'd1;
            exp_state = path[k];
            if (k == path.size() - 1) begin
                if (kind == 1) exp_ill = 1'b1;
                else           exp_ret = exp_ret + 32'd1;
            end
            check_all($sformatf("op%07b.k%0d", op, k));
        end
    endtask

    // While halted nothing may move regardless of opcode
    task automatic hold_halt(input int n);
        for (int i = 0; i < n; i++) begin
            one_edge(7'($urandom), 1'b0);
            check_all("halt_hold");
        end
    endtask

    function automatic logic [6:0] pick_legal(input int sel);
        case (sel)
            0: return OP_ARITH;
            1: return OP_ARITH_IMM;
            2: return OP_LOAD;
            3: return OP_STORE;
            4: return OP_BRANCH;
            5: return OP_JAL;
            default: return OP_JALR;
        endcase
    endfunction

    function automatic bit is_known(input logic [6:0] op);
        return op inside {OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
                          OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL};
    endfunction

    initial begin
        logic [6:0] op;
        int         rst_at;
        reset  = 1'b1;
        opcode = 7'd0;

        do_reset("reset0");
        do_reset("reset1");

        // arithmetic: 8 edges, cycles=8 retired=1
        do_instr(OP_ARITH, -1);
        check_val("arith_cycles", cycle_count, 32'd8);

        do_reset("reset2");
        do_instr(OP_LOAD, -1);
        check_val("load_cycles", cycle_count, 32'd12);
        do_instr(OP_STORE, -1);
        check_val("store_cycles", cycle_count, 32'd23);

        // branch then addi: 7 + 8 edges
        do_reset("reset3");
        do_instr(OP_BRANCH, -1);
        do_instr(OP_ARITH_IMM, -1);
        check_val("br_addi_cycles", cycle_count, 32'd15);
        check_val("br_addi_retired", retired_count, 32'd2);

        // ecall halts after 5 edges and stays frozen
        do_reset("reset4");
        do_instr(OP_ECALL, -1);
        check_val("ecall_cycles", cycle_count, 32'd5);
        hold_halt(20);
        do_reset("reset5");

        // illegal opcode
        do_instr(7'b1111111, -1);
        check_val("illegal_flag", {31'd0, illegal_op}, 32'd1);
        hold_halt(6);
        do_reset("reset6");

        // reset during MEM_3 of a load (present state MEM_3 at step 9)
        do_instr(OP_LOAD, 9);
        do_instr(OP_STORE, -1);
        check_val("after_rst_store", cycle_count, 32'd11);

        // randomized instruction stream
        for (int it = 0; it < 200; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                op = OP_ECALL;
            end else if (r < 16) begin
                do begin
                    op = 7'($urandom);
                end while (is_known(op));
            end else begin
                op = pick_legal(int'($urandom_range(0, 6)));
            end
            rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 11)) : -1;
            do_instr(op, rst_at);
            if (exp_state == 12) begin
                hold_halt(int'($urandom_range(1, 5)));
                do_reset("rand_rst");
            end
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
